serial_add_ctrl: RTL
====================

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits (legal range 2..64).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 SHALL have port sub  input  1  0 = A+B+C_in, 1 = A-B (two's complement).
REQ-006 SHALL have port A  input  WIDTH  operand A, captured on accepted start.
REQ-007 SHALL have port B  input  WIDTH  operand B, captured on accepted start.
REQ-008 SHALL have port C_in  input  1  carry in for add; ignored when sub=1.
REQ-009 SHALL have port fa_a, fa_b, fa_cin  output  1 each  bit drive to the external full_adder instance.
REQ-010 SHALL have port fa_r, fa_cout  input  1 each  sum and carry returned from that full_adder.
REQ-011 SHALL have port busy  output  1  high in RUN and DONE.
REQ-012 SHALL have port done  output  1  one-cycle pulse, result valid.
REQ-013 SHALL have port R  output  WIDTH  registered result.
REQ-014 SHALL have port C_out  output  1  final carry out.
REQ-015 SHALL have port ovf  output  1  signed overflow flag.

Function
REQ-016 SHALL implement FSM states IDLE, RUN and DONE.
REQ-017 IDLE with start=1 SHALL do all of the following at the edge:
- capture a_reg=A;
- capture b_reg=B, or ~B when sub=1;
- set carry=C_in, or 1 when sub=1;
- set cnt=0;
- clear R, C_out and ovf;
- go to RUN.
REQ-018 IDLE with start=0 SHALL hold all registers.
REQ-019 In RUN, fa_a=a_reg[cnt], fa_b=b_reg[cnt] and fa_cin=carry, combinationally from registers.
REQ-020 In IDLE and DONE, fa_a, fa_b and fa_cin SHALL be 0.
REQ-021 Each RUN edge SHALL do all of the following:
- R[cnt] <= fa_r;
- carry <= fa_cout;
- cnt <= cnt+1.
REQ-022 The RUN edge with cnt==WIDTH-1 SHALL also do all of the following:
- C_out <= fa_cout;
- ovf <= fa_cin XOR fa_cout;
- go to DONE.
REQ-023 RUN SHALL last exactly WIDTH cycles; done SHALL assert in the cycle WIDTH+1 cycles after the start edge.
REQ-024 DONE SHALL drive done=1 for exactly one cycle, then go to IDLE unconditionally.
REQ-025 start SHALL be ignored while busy=1 (RUN or DONE): no capture and no restart.
REQ-026 start=1 in the IDLE cycle after DONE SHALL be accepted (back-to-back throughput WIDTH+2 cycles).
REQ-027 R, C_out and ovf SHALL hold their last values in IDLE until the next accepted start.
REQ-028 cnt SHALL be ceil(log2(WIDTH)) bits wide and SHALL never exceed WIDTH-1.
REQ-029 sub=1 carry out SHALL follow two's-complement convention: C_out=1 means no borrow (A>=B unsigned).

Reset
REQ-030 rst=1 SHALL immediately, without waiting for clk, set all of the following:
- state=IDLE;
- cnt=0 and carry=0;
- a_reg and b_reg = 0;
- R=0, C_out=0, ovf=0;
- busy=0, done=0;
- fa_a, fa_b and fa_cin = 0.
REQ-031 Reset asserted mid-RUN SHALL abort the operation with no done pulse.
REQ-032 After rst deasserts, the first start SHALL be accepted normally.

Verification (WIDTH=8, bench instantiates full_adder on fa_* ports)
REQ-033 Add with carry: A=0x3C, B=0x45, C_in=1, sub=0 -> done on cycle 9 after start edge; R=0x82, C_out=0, ovf=1.
REQ-034 Carry out: A=0xFF, B=0x01, C_in=0, sub=0 -> R=0x00, C_out=1, ovf=0.
REQ-035 Subtract: A=0x10, B=0x20, sub=1 -> R=0xF0, C_out=0, ovf=0; then A=0x80, B=0x01, sub=1 -> R=0x7F, C_out=1, ovf=1.
REQ-036 Busy protection: start held high throughout, with A changed during RUN -> result reflects the originally captured A; next operation starts the cycle after done.
REQ-037 Reset mid-op: rst pulsed at RUN cycle 4 -> all outputs 0 asynchronously, no done pulse; a following start completes correctly.
REQ-038 Random: 1000 random A, B, C_in and sub -> R, C_out and ovf match a reference model; busy/done timing per REQ-023 every time.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial add/subtract sequencer driving an external full adder
// One operand bit per cycle, LSB first; the adder itself lives outside this block.
module serial_add_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C_in,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_r,
    input  logic             fa_cout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] R,
    output logic             C_out,
    output logic             ovf
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             accept;
    logic             step;
    logic             last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        step      = 1'b0;
        last      = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        fa_a      = 1'b0;
        fa_b      = 1'b0;
        fa_cin    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy   = 1'b1;
                step   = 1'b1;
                fa_a   = a_reg[cnt];
                fa_b   = b_reg[cnt];
                fa_cin = carry;
                if (cnt == LAST) begin
                    last      = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Subtraction is A + ~B + 1, so the inversion and the +1 are folded in at capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg <= '0;
            b_reg <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            R     <= '0;
            C_out <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            a_reg <= A;
            b_reg <= sub ? ~B : B;
            carry <= sub ? 1'b1 : C_in;
            cnt   <= '0;
            R     <= '0;
            C_out <= 1'b0;
            ovf   <= 1'b0;
        end else if (step) begin
            R[cnt] <= fa_r;
            carry  <= fa_cout;
            // Wrap to zero on the last bit so cnt never leaves 0..WIDTH-1.
            cnt    <= last ? '0 : cnt + 1'b1;
            if (last) begin
                C_out <= fa_cout;
                ovf   <= fa_cin ^ fa_cout;
            end
        end
    end

endmodule
